// File: rtl/debug_pkg.sv
// ============================================================================
//  Module   : debug_pkg
//  Purpose  : Shared state encodings, cmderr codes and regno map for the
//             hart-side debug run-control block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package debug_pkg;

    typedef logic [1:0] run_state_t;
    localparam run_state_t RUN_RUNNING     = 2'd0;
    localparam run_state_t RUN_HALT_WAIT   = 2'd1;
    localparam run_state_t RUN_HALTED      = 2'd2;
    localparam run_state_t RUN_RESUME_WAIT = 2'd3;

    typedef logic [1:0] cmd_state_t;
    localparam cmd_state_t CMD_IDLE  = 2'd0;
    localparam cmd_state_t CMD_ISSUE = 2'd1;
    localparam cmd_state_t CMD_WAIT  = 2'd2;
    localparam cmd_state_t CMD_DONE  = 2'd3;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam logic [15:0] CSR_MAX  = 16'h0FFF;
    localparam logic [15:0] GPR_BASE = 16'h1000;
    localparam logic [15:0] GPR_MAX  = 16'h101F;

    function automatic logic regno_supported(input logic [15:0] regno);
        return regno <= GPR_MAX;
    endfunction

    function automatic logic regno_is_gpr(input logic [15:0] regno);
        return regno > CSR_MAX;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debug_run_ctrl_if.sv
// ============================================================================
//  Module   : debug_run_ctrl_if
//  Purpose  : Abstract-command handshake and core register-port bundle.
//             Signal suffixes are relative to the run-control block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface debug_run_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_write_i;
    logic [15:0]     cmd_regno_i;
    logic [XLEN-1:0] cmd_wdata_i;
    logic            cmd_done_o;
    logic [2:0]      cmd_err_o;
    logic [XLEN-1:0] cmd_rdata_o;

    logic            reg_req_o;
    logic            reg_we_o;
    logic            reg_is_gpr_o;
    logic [11:0]     reg_addr_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic            reg_ack_i;
    logic [XLEN-1:0] reg_rdata_i;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_regno_i, cmd_wdata_i, reg_ack_i, reg_rdata_i,
        output cmd_ready_o, cmd_done_o, cmd_err_o, cmd_rdata_o,
        output reg_req_o, reg_we_o, reg_is_gpr_o, reg_addr_o, reg_wdata_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_regno_i, cmd_wdata_i, reg_ack_i, reg_rdata_i,
        input  cmd_ready_o, cmd_done_o, cmd_err_o, cmd_rdata_o,
        input  reg_req_o, reg_we_o, reg_is_gpr_o, reg_addr_o, reg_wdata_o
    );
endinterface

`default_nettype wire

// File: rtl/debug_abs_cmd.sv
// ============================================================================
//  Module   : debug_abs_cmd
//  Purpose  : Abstract register-access command sequencer with ack timeout
//             and read-data register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_abs_cmd import debug_pkg::*; #(
    parameter int CMD_TIMEOUT = 64,
    parameter int XLEN        = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_halted_i,
    input  logic                 hart_halted_i,
    output logic                 idle_o,
    output logic                 fin_o,
    debug_run_ctrl_if.slave      bus
);

    localparam int              CNT_W    = $clog2(CMD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_TIMEOUT - 1);

    cmd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic             we_q, gpr_q;
    logic [11:0]      addr_q;
    logic [XLEN-1:0]  wdata_q, rdata_q;

    logic accept, req_active, read_ack;
    logic ready, done, req;

    assign accept     = bus.cmd_valid_i && (state_q == CMD_IDLE);
    assign req_active = (state_q == CMD_ISSUE) || (state_q == CMD_WAIT);
    assign read_ack   = req_active && hart_halted_i && bus.reg_ack_i && !we_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CMD_IDLE;
            cnt_q   <= '0;
            err_q   <= CMDERR_NONE;
            we_q    <= 1'b0;
            gpr_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= bus.cmd_write_i;
                gpr_q   <= regno_is_gpr(bus.cmd_regno_i);
                addr_q  <= bus.cmd_regno_i[11:0];
                wdata_q <= bus.cmd_wdata_i;
            end
            if (read_ack) begin
                rdata_q <= bus.reg_rdata_i;
            end
        end
    end

    // Abort on hart leaving debug mode beats a same-cycle ack or timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            CMD_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (!run_halted_i) begin
                        state_d = CMD_DONE;
                        err_d   = CMDERR_HALTRESUME;
                    end else if (!regno_supported(bus.cmd_regno_i)) begin
                        state_d = CMD_DONE;
                        err_d   = CMDERR_NOTSUP;
                    end else begin
                        state_d = CMD_ISSUE;
                        err_d   = CMDERR_NONE;
                    end
                end
            end
            CMD_ISSUE, CMD_WAIT: begin
                if (!hart_halted_i) begin
                    state_d = CMD_DONE;
                    err_d   = CMDERR_HALTRESUME;
                end else if (bus.reg_ack_i) begin
                    state_d = CMD_DONE;
                    err_d   = CMDERR_NONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CMD_DONE;
                    err_d   = CMDERR_EXCEPTION;
                end else begin
                    state_d = CMD_WAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = CMD_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == CMD_IDLE);
        done  = (state_q == CMD_DONE);
        req   = req_active;
    end

    assign idle_o           = ready;
    assign fin_o            = done;
    assign bus.cmd_ready_o  = ready;
    assign bus.cmd_done_o   = done;
    assign bus.cmd_err_o    = done ? err_q : CMDERR_NONE;
    assign bus.cmd_rdata_o  = rdata_q;
    assign bus.reg_req_o    = req;
    assign bus.reg_we_o     = we_q;
    assign bus.reg_is_gpr_o = gpr_q;
    assign bus.reg_addr_o   = addr_q;
    assign bus.reg_wdata_o  = wdata_q;

endmodule

`default_nettype wire

// File: rtl/debug_run_ctrl.sv
// ============================================================================
//  Module   : debug_run_ctrl
//  Purpose  : Hart-side halt/resume control, dmstatus bits and abstract
//             command sequencing. Optional macro DEBUG_RESETHALT_EN adds
//             halt-on-reset via dm_resethaltreq_i.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_run_ctrl import debug_pkg::*; #(
    parameter int CMD_TIMEOUT = 64,
    parameter int XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dm_haltreq_i,
    input  logic            dm_resumereq_i,
    input  logic            dm_ackhavereset_i,
`ifdef DEBUG_RESETHALT_EN
    input  logic            dm_resethaltreq_i,
`endif
    input  logic            hart_halted_i,
    output logic            debug_strobe_o,
    output logic            resume_o,
    output logic            halted_o,
    output logic            running_o,
    output logic            resumeack_o,
    output logic            havereset_o,
    debug_run_ctrl_if.slave bus
);

    run_state_t state_q, state_d;
    logic       strobe_q, strobe_d;
    logic       resumeack_q, resumeack_d;
    logic       pend_q, pend_d;
    logic       havereset_q;
    logic       cmd_idle, cmd_fin;
    logic       halt_req, resume_go;

`ifdef DEBUG_RESETHALT_EN
    logic boot_q;
    always_ff @(posedge clk_i) begin
        boot_q <= rst_i;
    end
    assign halt_req = dm_haltreq_i || (boot_q && dm_resethaltreq_i);
`else
    assign halt_req = dm_haltreq_i;
`endif

    // A resume deferred by a busy command is taken on the command's done cycle.
    assign resume_go = !dm_haltreq_i && (dm_resumereq_i || pend_q) && (cmd_idle || cmd_fin);

    debug_abs_cmd #(
        .CMD_TIMEOUT (CMD_TIMEOUT),
        .XLEN        (XLEN)
    ) u_abs_cmd (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_halted_i  (state_q == RUN_HALTED),
        .hart_halted_i (hart_halted_i),
        .idle_o        (cmd_idle),
        .fin_o         (cmd_fin),
        .bus           (bus)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN_RUNNING;
            strobe_q    <= 1'b0;
            resumeack_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            resumeack_q <= resumeack_d;
            pend_q      <= pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            havereset_q <= 1'b1;
        end else if (dm_ackhavereset_i) begin
            havereset_q <= 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        strobe_d    = 1'b0;
        resumeack_d = resumeack_q;
        pend_d      = 1'b0;
        case (state_q)
            RUN_RUNNING: begin
                if (hart_halted_i) begin
                    state_d = RUN_HALTED;
                end else if (halt_req) begin
                    state_d  = RUN_HALT_WAIT;
                    strobe_d = 1'b1;
                end
            end
            RUN_HALT_WAIT: begin
                if (hart_halted_i) begin
                    state_d = RUN_HALTED;
                end
            end
            RUN_HALTED: begin
                pend_d = pend_q && !dm_haltreq_i;
                if (resume_go) begin
                    state_d     = RUN_RESUME_WAIT;
                    resumeack_d = 1'b0;
                    pend_d      = 1'b0;
                end else if (dm_resumereq_i && !dm_haltreq_i) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                if (!hart_halted_i) begin
                    state_d     = RUN_RUNNING;
                    resumeack_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        resume_o  = (state_q == RUN_RESUME_WAIT);
        halted_o  = (state_q == RUN_HALTED);
        running_o = (state_q == RUN_RUNNING) || (state_q == RUN_HALT_WAIT);
    end

    assign debug_strobe_o = strobe_q;
    assign resumeack_o    = resumeack_q;
    assign havereset_o    = havereset_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_run_ctrl.sv
// ============================================================================
//  Module   : tb_debug_run_ctrl
//  Purpose  : Self-checking bench for debug_run_ctrl; the bench plays both
//             the Debug Module and the core register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debug_run_ctrl;

    localparam int T    = 8;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, haltreq, resumereq, ackhr, hart_halted;
    logic strobe, resume, halted, running, resumeack, havereset;
`ifdef DEBUG_RESETHALT_EN
    logic resethaltreq;
`endif

    debug_run_ctrl_if #(.XLEN(XLEN)) bus ();

    debug_run_ctrl #(.CMD_TIMEOUT(T), .XLEN(XLEN)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .dm_haltreq_i      (haltreq),
        .dm_resumereq_i    (resumereq),
        .dm_ackhavereset_i (ackhr),
`ifdef DEBUG_RESETHALT_EN
        .dm_resethaltreq_i (resethaltreq),
`endif
        .hart_halted_i     (hart_halted),
        .debug_strobe_o    (strobe),
        .resume_o          (resume),
        .halted_o          (halted),
        .running_o         (running),
        .resumeack_o       (resumeack),
        .havereset_o       (havereset),
        .bus               (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: core register file, hart mode, last command read data.
    logic [31:0] mem [int];
    bit          m_halted;
    logic [31:0] m_rdata;

    function automatic logic [31:0] mem_rd(input int k);
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command, serves the register port as the core would, and
    // compares completion timing/result against the rules for that command.
    task automatic run_cmd(input string tag, input logic wr, input logic [15:0] regno,
                           input logic [31:0] wdata, input int ack_dly, input int resume_at);
        int          exp_err, exp_lat, exp_reqs, lat, reqs;
        bit          fld_ok, rdy_ok;
        bit          gpr;
        logic [11:0] exp_addr;
        logic [31:0] exp_rd, got_rd;
        logic [2:0]  got_err;
        gpr      = (regno >= 16'h1000);
        exp_addr = 12'(gpr ? regno - 16'h1000 : regno);
        if (!m_halted) begin
            exp_err = 4; exp_lat = 1; exp_reqs = 0;
        end else if (regno > 16'h101F) begin
            exp_err = 2; exp_lat = 1; exp_reqs = 0;
        end else if (ack_dly < T) begin
            exp_err = 0; exp_lat = ack_dly + 2; exp_reqs = ack_dly + 1;
        end else begin
            exp_err = 3; exp_lat = T + 1; exp_reqs = T;
        end
        exp_rd = (exp_err == 0 && !wr) ? mem_rd(int'(regno)) : m_rdata;

        chk({tag, " ready"}, 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_regno_i = regno;
        bus.cmd_wdata_i = wdata;
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_regno_i = 16'(~regno);
        bus.cmd_wdata_i = ~wdata;
        lat = 0; reqs = 0; fld_ok = 1; rdy_ok = 1;
        got_err = '0; got_rd = '0;
        for (int c = 1; c <= T + 6 && lat == 0; c++) begin
            if (bus.cmd_done_o === 1'b1) begin
                lat     = c;
                got_err = bus.cmd_err_o;
                got_rd  = bus.cmd_rdata_o;
            end else begin
                if (bus.cmd_ready_o !== 1'b0) rdy_ok = 0;
                if (bus.reg_req_o === 1'b1) begin
                    if (bus.reg_we_o !== wr || bus.reg_is_gpr_o !== gpr ||
                        bus.reg_addr_o !== exp_addr || (wr && bus.reg_wdata_o !== wdata))
                        fld_ok = 0;
                    if (reqs == ack_dly) begin
                        bus.reg_ack_i   = 1'b1;
                        bus.reg_rdata_i = wr ? $urandom : mem_rd(int'(regno));
                        if (wr && !(gpr && regno[4:0] == 5'd0)) mem[int'(regno)] = wdata;
                    end
                    reqs++;
                end
                if (c == resume_at) resumereq = 1'b1;
                tick();
                bus.reg_ack_i   = 1'b0;
                bus.reg_rdata_i = $urandom;
                resumereq       = 1'b0;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " err"}, 32'(got_err), 32'(exp_err));
        chk({tag, " rdata"}, got_rd, exp_rd);
        chk({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({tag, " req_fields"}, 32'(fld_ok), 32'd1);
        chk({tag, " busy_ready"}, 32'(rdy_ok), 32'd1);
        m_rdata = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] regno;
        rst = 1'b1; haltreq = 1'b0; resumereq = 1'b0; ackhr = 1'b0; hart_halted = 1'b0;
`ifdef DEBUG_RESETHALT_EN
        resethaltreq = 1'b0;
`endif
        bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_regno_i = '0;
        bus.cmd_wdata_i = '0;   bus.reg_ack_i   = 1'b0; bus.reg_rdata_i = '0;
        m_halted = 0; m_rdata = '0;
        mem[32'h1005] = 32'hDEADBEEF;

        // Reset values
        tick(); tick();
        chk("rst havereset", 32'(havereset), 32'd1);
        chk("rst running", 32'(running), 32'd1);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst strobe", 32'(strobe), 32'd0);
        chk("rst resume", 32'(resume), 32'd0);
        chk("rst resumeack", 32'(resumeack), 32'd0);
        chk("rst reg_req", 32'(bus.reg_req_o), 32'd0);
        chk("rst done", 32'(bus.cmd_done_o), 32'd0);
        rst = 1'b0;
        tick();
        chk("post-rst ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("post-rst strobe", 32'(strobe), 32'd0);

        ackhr = 1'b1; tick(); ackhr = 1'b0;
        chk("ackhavereset", 32'(havereset), 32'd0);

        // Command while running
        run_cmd("cmd_running", 1'b0, 16'h1001, 32'h0, 0, 0);
        tick();

        // Halt via haltreq; haltreq dropped in HALT_WAIT does not cancel
        haltreq = 1'b1;
        tick();
        chk("T1 strobe", 32'(strobe), 32'd1);
        chk("T1 running hw", 32'(running), 32'd1);
        tick();
        chk("T1 strobe single", 32'(strobe), 32'd0);
        haltreq = 1'b0;
        tick();
        chk("T1 not yet halted", 32'(halted), 32'd0);
        hart_halted = 1'b1;
        tick();
        chk("T1 halted", 32'(halted), 32'd1);
        chk("T1 running", 32'(running), 32'd0);
        m_halted = 1;

        // Read x5 acked on first request cycle
        run_cmd("T3 rd_x5", 1'b0, 16'h1005, 32'h0, 0, 0);
        tick();
        chk("T3 ready after", 32'(bus.cmd_ready_o), 32'd1);

        // Randomized commands while halted
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       regno = 16'(16'h0300 + $urandom_range(0, 3));
                1:       regno = 16'($urandom_range(16'h1020, 16'hFFFF));
                default: regno = 16'(16'h1000 + $urandom_range(0, 7));
            endcase
            run_cmd($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), regno,
                    $urandom, $urandom_range(0, T + 1), 0);
            tick();
        end

        // Boundaries: unsupported regno, timeout, x0 write ignored
        run_cmd("T4 regno_2000", 1'b0, 16'h2000, 32'h0, 0, 0);
        tick();
        run_cmd("T4 timeout", 1'b0, 16'h0300, 32'h0, T + 3, 0);
        tick();
        run_cmd("x0 write", 1'b1, 16'h1000, 32'hA5A5A5A5, 1, 0);
        tick();
        run_cmd("x0 read", 1'b0, 16'h1000, 32'h0, 0, 0);
        tick();

        // Resume requested during a busy write
        run_cmd("T5 wr_busy", 1'b1, 16'h1003, $urandom, 2, 1);
        chk("T5 resume at done", 32'(resume), 32'd0);
        tick();
        chk("T5 resume after done", 32'(resume), 32'd1);
        chk("T5 resumeack clr", 32'(resumeack), 32'd0);
        hart_halted = 1'b0;
        tick();
        m_halted = 0;
        chk("T5 running", 32'(running), 32'd1);
        chk("T5 resumeack", 32'(resumeack), 32'd1);

        // Hart halts by itself: no strobe
        hart_halted = 1'b1;
        tick();
        m_halted = 1;
        chk("selfhalt halted", 32'(halted), 32'd1);
        chk("selfhalt strobe", 32'(strobe), 32'd0);

        // resumereq with haltreq high is dropped
        haltreq = 1'b1; resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        chk("T5 drop resume", 32'(resume), 32'd0);
        tick();
        chk("T5 drop halted", 32'(halted), 32'd1);
        haltreq = 1'b0;
        tick();
        chk("T5 no late resume", 32'(resume), 32'd0);

        // Plain resume
        resumereq = 1'b1;
        tick();
        resumereq = 1'b0;
        chk("T2 resume", 32'(resume), 32'd1);
        chk("T2 resumeack", 32'(resumeack), 32'd0);
        tick(); tick();
        chk("T2 resume held", 32'(resume), 32'd1);
        hart_halted = 1'b0;
        tick();
        m_halted = 0;
        chk("T2 resume clr", 32'(resume), 32'd0);
        chk("T2 resumeack set", 32'(resumeack), 32'd1);
        chk("T2 running", 32'(running), 32'd1);

        // Reset mid-command, with ackhavereset in the same cycle
        hart_halted = 1'b1;
        tick();
        m_halted = 1;
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_regno_i = 16'h1002;
        tick();
        bus.cmd_valid_i = 1'b0;
        tick();
        chk("midrst req", 32'(bus.reg_req_o), 32'd1);
        rst = 1'b1; ackhr = 1'b1;
        tick();
        ackhr = 1'b0;
        chk("midrst done", 32'(bus.cmd_done_o), 32'd0);
        chk("midrst req drop", 32'(bus.reg_req_o), 32'd0);
        chk("T6 havereset", 32'(havereset), 32'd1);
        hart_halted = 1'b0;
        m_halted = 0;
`ifdef DEBUG_RESETHALT_EN
        resethaltreq = 1'b1;
`endif
        tick();
        rst = 1'b0;
        chk("T6 running", 32'(running), 32'd1);
        tick();
        chk("midrst no done", 32'(bus.cmd_done_o), 32'd0);
`ifdef DEBUG_RESETHALT_EN
        chk("T6 resethalt strobe", 32'(strobe), 32'd1);
        resethaltreq = 1'b0;
        tick();
        chk("T6 resethalt single", 32'(strobe), 32'd0);
        chk("T6 resethalt hw", 32'(running), 32'd1);
`else
        chk("T6 no strobe", 32'(strobe), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
